// File: rtl/key_char_queue_pkg.sv
// rtl/key_char_queue_pkg.sv - shared game character codes and char-code type
package key_char_queue_pkg;

    typedef logic [4:0] char_t;

    localparam char_t CH_NONE  = 5'd0;
    localparam char_t CH_SPACE = 5'd27;
    localparam char_t CH_BKSP  = 5'd28;
    localparam char_t CH_ENTER = 5'd29;

endpackage

// File: rtl/key_char_queue_scan_to_char.sv
// rtl/key_char_queue_scan_to_char.sv - combinational PS/2 set-2 scan code to char code lookup
module scan_to_char
    import key_char_queue_pkg::*;
(
    input  logic [7:0] scan,
    output char_t      code
);

    always_comb begin
        code = CH_NONE;
        case (scan)
            8'h1C: code = 5'd1;
            8'h32: code = 5'd2;
            8'h21: code = 5'd3;
            8'h23: code = 5'd4;
            8'h24: code = 5'd5;
            8'h2B: code = 5'd6;
            8'h34: code = 5'd7;
            8'h33: code = 5'd8;
            8'h43: code = 5'd9;
            8'h3B: code = 5'd10;
            8'h42: code = 5'd11;
            8'h4B: code = 5'd12;
            8'h3A: code = 5'd13;
            8'h31: code = 5'd14;
            8'h44: code = 5'd15;
            8'h4D: code = 5'd16;
            8'h15: code = 5'd17;
            8'h2D: code = 5'd18;
            8'h1B: code = 5'd19;
            8'h2C: code = 5'd20;
            8'h3C: code = 5'd21;
            8'h2A: code = 5'd22;
            8'h1D: code = 5'd23;
            8'h22: code = 5'd24;
            8'h35: code = 5'd25;
            8'h1A: code = 5'd26;
            8'h29: code = CH_SPACE;
            8'h66: code = CH_BKSP;
            8'h5A: code = CH_ENTER;
            default: code = CH_NONE;
        endcase
    end

endmodule

// File: rtl/key_char_queue.sv
// rtl/key_char_queue.sv - scan-code decode, typematic repeat filter and character FIFO
module key_char_queue
    import key_char_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     key_valid,
    input  logic [7:0]               last_change,
    input  logic [127:0]             key_down,
    output char_t                    char_code,
    output logic                     char_valid,
    input  logic                     char_ready,
    output logic [7:0]               drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

    char_t          dec_code;
    logic           down_bit;
    logic           make_ev;
    logic           brk_ev;
    logic           repeat_hit;
    logic           accept;

    logic [7:0]     last_code;
    logic           held;
    logic           s1_valid;
    char_t          s1_code;

    char_t          mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           push;
    logic           pop;
    logic           full;
    logic           wr_en;
    logic [CW-1:0]  level_nxt;

    scan_to_char u_scan_to_char (
        .scan (last_change),
        .code (dec_code)
    );

    // Codes above 7F have no entry in the held map and are never makes.
    assign down_bit   = last_change[7] ? 1'b0 : key_down[last_change[6:0]];
    assign make_ev    = key_valid && down_bit;
    assign brk_ev     = key_valid && !down_bit;
    assign repeat_hit = held && (last_code == last_change);
    assign accept     = make_ev && (dec_code != CH_NONE) && !repeat_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_code   <= CH_NONE;
            last_code <= 8'h00;
            held      <= 1'b0;
        end else if (!enable) begin
            s1_valid <= 1'b0;
            held     <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_code   <= dec_code;
                last_code <= last_change;
                held      <= 1'b1;
            end else if (brk_ev && (last_change == last_code)) begin
                held <= 1'b0;
            end
        end
    end

    assign push  = s1_valid && enable;
    assign pop   = char_valid && char_ready;
    assign full  = (level == FULL_LEVEL);
    // When full, a simultaneous pop frees the head slot that wr_ptr aliases.
    assign wr_en = rst && push && (!full || pop);

    always_comb begin
        level_nxt = level;
        if (wr_en && !pop)
            level_nxt = level + 1'b1;
        else if (!wr_en && pop)
            level_nxt = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= s1_code;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            char_valid <= 1'b0;
            drop_cnt   <= 8'd0;
        end else if (!enable) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            char_valid <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
            level      <= level_nxt;
            char_valid <= (level_nxt != '0);
        end
    end

    assign char_code = char_valid ? mem[rd_ptr] : CH_NONE;

endmodule

// File: tb/tb_key_char_queue.sv
// tb/tb_key_char_queue.sv - directed self-checking bench for key_char_queue
module tb_key_char_queue;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         key_valid;
    logic [7:0]   last_change;
    logic [127:0] key_down;
    logic [4:0]   char_code;
    logic         char_valid;
    logic         char_ready;
    logic [7:0]   drop_cnt;
    logic [2:0]   level;

    int compared;
    int mismatched;

    key_char_queue #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .key_valid   (key_valid),
        .last_change (last_change),
        .key_down    (key_down),
        .char_code   (char_code),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .drop_cnt    (drop_cnt),
        .level       (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [7:0] c, input logic d);
        key_down[c[6:0]] = d;
        last_change      = c;
        key_valid        = 1'b1;
        tick();
        key_valid        = 1'b0;
    endtask

    task automatic pop_one();
        char_ready = 1'b1;
        tick();
        char_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        compared++;
        if (char_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %0d want 0", char_valid); end
        compared++;
        if (char_code !== 5'd0) begin mismatched++; $display("FAIL reset_code got %0d want 0", char_code); end
        compared++;
        if (level !== 3'd0) begin mismatched++; $display("FAIL reset_level got %0d want 0", level); end
        compared++;
        if (drop_cnt !== 8'd0) begin mismatched++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        enable = 1'b1;
        tick();
        ev(8'h1C, 1'b1);
        compared++;
        if (char_valid !== 1'b0) begin mismatched++; $display("FAIL basic_n1_valid got %0d want 0", char_valid); end
        tick();
        compared++;
        if (char_valid !== 1'b1) begin mismatched++; $display("FAIL basic_n2_valid got %0d want 1", char_valid); end
        compared++;
        if (char_code !== 5'd1) begin mismatched++; $display("FAIL basic_code got %0d want 1", char_code); end
        compared++;
        if (level !== 3'd1) begin mismatched++; $display("FAIL basic_level got %0d want 1", level); end
        pop_one();
        compared++;
        if (char_valid !== 1'b0) begin mismatched++; $display("FAIL basic_pop_valid got %0d want 0", char_valid); end
        compared++;
        if (level !== 3'd0) begin mismatched++; $display("FAIL basic_pop_level got %0d want 0", level); end
        ev(8'h1C, 1'b0);
        tick();
    endtask

    task automatic test_repeat();
        ev(8'h24, 1'b1);
        ev(8'h24, 1'b1);
        ev(8'h24, 1'b1);
        ev(8'h24, 1'b0);
        ev(8'h24, 1'b1);
        tick();
        tick();
        compared++;
        if (level !== 3'd2) begin mismatched++; $display("FAIL repeat_level got %0d want 2", level); end
        compared++;
        if (char_code !== 5'd5) begin mismatched++; $display("FAIL repeat_code0 got %0d want 5", char_code); end
        pop_one();
        compared++;
        if (char_code !== 5'd5) begin mismatched++; $display("FAIL repeat_code1 got %0d want 5", char_code); end
        pop_one();
        compared++;
        if (level !== 3'd0) begin mismatched++; $display("FAIL repeat_empty got %0d want 0", level); end
        ev(8'h24, 1'b0);
        tick();
    endtask

    task automatic test_overflow();
        logic [7:0] codes [6];
        logic [4:0] order [4];
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
        order = '{5'd23, 5'd5, 5'd18, 5'd26};
        char_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ev(codes[i], 1'b1);
            ev(codes[i], 1'b0);
        end
        tick();
        tick();
        compared++;
        if (level !== 3'd4) begin mismatched++; $display("FAIL ovf_level got %0d want 4", level); end
        compared++;
        if (drop_cnt !== 8'd2) begin mismatched++; $display("FAIL ovf_drop got %0d want 2", drop_cnt); end
        compared++;
        if (char_code !== 5'd17) begin mismatched++; $display("FAIL ovf_head got %0d want 17", char_code); end
        // z sits in stage 1; pop at the write edge so both happen while full
        ev(8'h1A, 1'b1);
        pop_one();
        compared++;
        if (level !== 3'd4) begin mismatched++; $display("FAIL pushpop_level got %0d want 4", level); end
        compared++;
        if (drop_cnt !== 8'd2) begin mismatched++; $display("FAIL pushpop_drop got %0d want 2", drop_cnt); end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (char_code !== order[i]) begin
                mismatched++;
                $display("FAIL pushpop_order%0d got %0d want %0d", i, char_code, order[i]);
            end
            pop_one();
        end
        compared++;
        if (char_valid !== 1'b0) begin mismatched++; $display("FAIL pushpop_drain got %0d want 0", char_valid); end
        ev(8'h1A, 1'b0);
        tick();
    endtask

    task automatic test_flush();
        ev(8'h12, 1'b1);
        tick();
        tick();
        compared++;
        if (level !== 3'd0) begin mismatched++; $display("FAIL unmapped_level got %0d want 0", level); end
        ev(8'h12, 1'b0);
        ev(8'h1C, 1'b1);
        ev(8'h1C, 1'b0);
        ev(8'h32, 1'b1);
        ev(8'h32, 1'b0);
        ev(8'h21, 1'b1);
        ev(8'h21, 1'b0);
        tick();
        compared++;
        if (level !== 3'd3) begin mismatched++; $display("FAIL flush_pre got %0d want 3", level); end
        enable = 1'b0;
        tick();
        compared++;
        if (level !== 3'd0) begin mismatched++; $display("FAIL flush_level got %0d want 0", level); end
        compared++;
        if (char_valid !== 1'b0) begin mismatched++; $display("FAIL flush_valid got %0d want 0", char_valid); end
        compared++;
        if (drop_cnt !== 8'd2) begin mismatched++; $display("FAIL flush_drop got %0d want 2", drop_cnt); end
        enable = 1'b1;
        tick();
        ev(8'h23, 1'b1);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        tick();
        compared++;
        if (level !== 3'd0) begin mismatched++; $display("FAIL inflight_level got %0d want 0", level); end
        ev(8'h23, 1'b0);
        rst = 1'b0;
        tick();
        compared++;
        if (drop_cnt !== 8'd0) begin mismatched++; $display("FAIL rst_drop got %0d want 0", drop_cnt); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_special();
        logic [7:0] codes [3];
        logic [4:0] exp   [3];
        codes = '{8'h29, 8'h66, 8'h5A};
        exp   = '{5'd27, 5'd28, 5'd29};
        for (int i = 0; i < 3; i++) begin
            ev(codes[i], 1'b1);
            ev(codes[i], 1'b0);
        end
        tick();
        compared++;
        if (level !== 3'd3) begin mismatched++; $display("FAIL special_level got %0d want 3", level); end
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (char_code !== exp[i]) begin
                mismatched++;
                $display("FAIL special_code%0d got %0d want %0d", i, char_code, exp[i]);
            end
            pop_one();
        end
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        rst         = 1'b0;
        enable      = 1'b0;
        key_valid   = 1'b0;
        last_change = 8'h00;
        key_down    = '0;
        char_ready  = 1'b0;
        test_reset();
        test_basic();
        test_repeat();
        test_overflow();
        test_flush();
        test_special();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
